// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, synchronous ROM drive, one-entry skid buffer toward decode.
// Latency: two edges from ROM issue to output register; stall holds the output and suppresses issue.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_enable,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic        instruction_valid,
    output logic [31:0] instruction_pc,
    output logic [31:0] instruction
);

    logic        running_q, running_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        issued_valid_q, issued_valid_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_data_q, out_data_d;
    logic        redirect;

    // A redirect is only honoured once decode actually accepts the branch.
    assign redirect    = running_q & branch_flag & ~stall;
    assign rom_enable  = running_q & ~stall;
    assign rom_address = redirect ? {branch_target[31:2], 2'b00} : fetch_pc_q;

    assign instruction_valid = out_valid_q;
    assign instruction_pc    = out_pc_q;
    assign instruction       = out_data_q;

    always_comb begin
        running_d      = 1'b1;
        fetch_pc_d     = fetch_pc_q;
        issued_valid_d = rom_enable;
        issued_pc_d    = issued_pc_q;
        skid_valid_d   = skid_valid_q;
        skid_pc_d      = skid_pc_q;
        skid_data_d    = skid_data_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_data_d     = out_data_q;

        if (rom_enable) begin
            issued_pc_d = rom_address;
            fetch_pc_d  = rom_address + 32'd4;
        end

        if (!stall) begin
            // Skid and in-flight never coexist here: the skid only fills while stalled,
            // and a stalled cycle issues nothing.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (issued_valid_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = issued_pc_q;
                out_data_d  = rom_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (issued_valid_q) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = issued_pc_q;
            skid_data_d  = rom_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running_q      <= 1'b0;
            fetch_pc_q     <= RESET_PC;
            issued_valid_q <= 1'b0;
            issued_pc_q    <= 32'h0;
            skid_valid_q   <= 1'b0;
            skid_pc_q      <= 32'h0;
            skid_data_q    <= 32'h0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= 32'h0;
            out_data_q     <= 32'h0;
        end else begin
            running_q      <= running_d;
            fetch_pc_q     <= fetch_pc_d;
            issued_valid_q <= issued_valid_d;
            issued_pc_q    <= issued_pc_d;
            skid_valid_q   <= skid_valid_d;
            skid_pc_q      <= skid_pc_d;
            skid_data_q    <= skid_data_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_data_q     <= out_data_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the five-stage CPU inside `sopc`. It generates the program counter, drives the synchronous instruction ROM, and presents one instruction per cycle to decode. It honours decode's stall through a one-entry skid buffer and redirects on jump/branch with MIPS delay-slot semantics.

## Interface

**Parameters**
- `RESET_PC`, default 32'h00000000: first fetch address after reset.

**Ports**
- `clock` — input, 1: rising-edge clock.
- `reset` — input, 1: asynchronous, active-low; low clears all state immediately.
- `stall` — input, 1: decode cannot accept; hold the output and issue no fetch.
- `branch_flag` — input, 1: decode accepted a taken jump/branch this cycle. Sampled only when `stall`=0.
- `branch_target` — input, 32: redirect address; bits [1:0] are ignored and treated as 0.
- `rom_enable` — output, 1: ROM read strobe.
- `rom_address` — output, 32: ROM byte address.
- `rom_data` — input, 32: ROM word, valid the cycle after the read was issued.
- `instruction_valid` — output, 1: output register holds a real instruction.
- `instruction_pc` — output, 32: address of `instruction`.
- `instruction` — output, 32: instruction word to decode.

## Operation

**State**
- `running`
- `fetch_pc` (32 bits)
- `issued_valid`, `issued_pc`: read issued last cycle; its data is on `rom_data` now.
- `skid_valid`, `skid_pc`, `skid_data`
- output registers.

**Reset (reset=0)**
- All flags are 0.
- `fetch_pc`=`RESET_PC`.
- Outputs: `instruction_valid`=0, `instruction_pc`=0, `instruction`=0, `rom_enable`=0, `rom_address`=`RESET_PC`.

**Start-up**
- `running` goes to 1 on the first clock edge after reset release.

**Fetch issue (combinational)**
- `rom_enable` = `running` & ~`stall`.
- `rom_address` = (`branch_flag` & ~`stall`) ? {`branch_target`[31:2],2'b00} : `fetch_pc`.

**On each edge with `rom_enable`=1**
- `issued_valid`<=1, `issued_pc`<=`rom_address`.
- `fetch_pc`<=`rom_address`+4. Arithmetic is modulo 2^32, so 32'hFFFFFFFC wraps to 0.

**On each edge with `rom_enable`=0**
- `issued_valid`<=0; `fetch_pc` holds.

**Output update when `stall`=0**
- If `skid_valid`: output <= skid, and `skid_valid`<=0.
- Else if `issued_valid`: output <= (`issued_pc`, `rom_data`).
- Else: `instruction_valid`<=0.

**Output update when `stall`=1**
- The output registers hold.
- If `issued_valid`, the response is captured into the skid buffer.

**Invariant**
- At most one instruction exists beyond the output register (issued or skid). The skid buffer can never overflow: a stalled cycle issues nothing, and the skid buffer is filled only in stalled cycles.

**Delay slot**
- When decode accepts a branch at address B, B+4 is already issued or in the skid buffer and is delivered next, unchanged.
- The target is issued in the same cycle as `branch_flag`.
- Address B+8 is never fetched.

**Reset mid-operation**
- All in-flight and skid contents are discarded at once.
- Fetching restarts from `RESET_PC`.

## Timing

**Start-up latency**
- Edge E0 after release sets `running`.
- `RESET_PC` is issued in the cycle after E0.
- `instruction_valid`=1 with `instruction_pc`=`RESET_PC` after edge E2.

**Steady state**
- One instruction per cycle; `instruction_pc` increases by 4 each cycle.

**Branch**
- `branch_flag` in cycle t, with the output holding B:
  - t+1: output = B+4 (delay slot).
  - t+2: output = target.
- No bubble is inserted.

**Stall**
- Each stalled cycle holds the output.
- On release:
  - The skid entry appears on the next edge.
  - The first new fetch is issued in the release cycle.
- No instruction is lost or duplicated.

**`branch_flag` with `stall`=1**
- Ignored. Decode must hold the flag until it is accepted.

**Simultaneous `stall` release and `branch_flag`**
- The skid entry (the delay slot) moves to the output.
- The target is issued in the same cycle.

## Test plan

1. **Reset and linear fetch.**
   - Stimulus: hold reset=0 for 10 cycles, then release.
   - Required response: all outputs 0 during reset; `instruction_pc` = 0,4,8,12 on consecutive cycles from E2.
2. **Jump with delay slot.**
   - Stimulus: ROM 0x0 is `j 0x20`, 0x4 is `ori $1,$0,1`; pulse `branch_flag` with target 0x20 while the output holds 0x0.
   - Required response: output pcs 0x0, 0x4, 0x20, 0x24; 0x8 is never on `rom_address`.
3. **Stall with skid.**
   - Stimulus: assert `stall` for 3 cycles while the output holds 0x8.
   - Required response:
     - `rom_enable`=0 for 3 cycles and the output stays 0x8.
     - After release: 0xC, then 0x10 on consecutive cycles.
4. **Branch coincident with skid drain.**
   - Stimulus: stall for 1 cycle with the output holding B=0x10, release, and assert `branch_flag` with target 0x40 in the release cycle.
   - Required response: output sequence 0x14, 0x40, 0x44.
5. **Wrap-around and misaligned target.**
   - Stimulus:
     - `RESET_PC`=32'hFFFFFFF8, no branches.
     - Separately: `branch_flag` with target 0x23.
   - Required response:
     - Output pcs FFFFFFF8, FFFFFFFC, 00000000.
     - 0x20 is issued for the 0x23 target.
6. **Reset mid-stream.**
   - Stimulus: drive reset=0 asynchronously while a stall and a skid entry are pending.
   - Required response:
     - `instruction_valid`=0 immediately.
     - After release, fetch restarts from `RESET_PC` with start-up latency E2.
